// File: rtl/dot_pkg.sv
// Shared constants and types for the dot-product accumulator.
//   DATA_W_DEF / ACC_W_DEF : default operand and accumulator widths
//   state_e                : controller states (ACCUM collects terms, DONE presents the result)
package dot_pkg;

  localparam int unsigned DATA_W_DEF = 5;
  localparam int unsigned ACC_W_DEF  = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_mac.sv
// Signed multiply with saturating accumulate.
//   acc      : current signed accumulator (ACC_W)
//   a, b     : signed operands (DATA_W); the product is kept at full 2*DATA_W precision
//   next_acc : acc + a*b clamped to the signed ACC_W range
//   clamped  : high when the clamp was applied
module sat_mac
  import dot_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ACC_W  = ACC_W_DEF
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [ACC_W-1:0]  next_acc,
  output logic                     clamped
);

  localparam int unsigned PROD_W = 2 * DATA_W;
  // One guard bit above the wider of accumulator and product so the sum cannot wrap.
  localparam int unsigned SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;

  localparam logic signed [SUM_W-1:0] MaxV = {{(SUM_W - ACC_W + 1){1'b0}}, {(ACC_W - 1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MinV = {{(SUM_W - ACC_W + 1){1'b1}}, {(ACC_W - 1){1'b0}}};

  logic signed [PROD_W-1:0] prod;
  logic signed [SUM_W-1:0]  sum;

  always_comb begin
    prod = PROD_W'(a) * PROD_W'(b);
    sum  = SUM_W'(acc) + SUM_W'(prod);
    if (sum > MaxV) begin
      next_acc = MaxV[ACC_W-1:0];
      clamped  = 1'b1;
    end else if (sum < MinV) begin
      next_acc = MinV[ACC_W-1:0];
      clamped  = 1'b1;
    end else begin
      next_acc = sum[ACC_W-1:0];
      clamped  = 1'b0;
    end
  end

endmodule

// File: rtl/dot_accum.sv
// Streaming dot-product accumulator: collects N_TERMS signed operand pairs, presents the
// saturated sum, and holds it until the downstream handshake.
//   clk, rst            : rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready   : operand-pair handshake (in_a activation, in_b weight)
//   out_valid/out_ready : result handshake (out_sum result, out_sat sticky saturation)
// Build option: define DOT_ACCUM_RELU_EN to present max(result, 0) on out_sum.
module dot_accum
  import dot_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ACC_W   = ACC_W_DEF,
  parameter int unsigned N_TERMS = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_sum,
  output logic                     out_sat
);

  // N_TERMS is at most 255, so 8 bits cover the term index.
  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(N_TERMS - 1);

  state_e                   state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     sat_q, sat_d;

  logic signed [ACC_W-1:0]  mac_next;
  logic                     mac_clamped;

  sat_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_sat_mac (
    .acc      (acc_q),
    .a        (in_a),
    .b        (in_b),
    .next_acc (mac_next),
    .clamped  (mac_clamped)
  );

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sat_d   = sat_q;
    unique case (state_q)
      ACCUM: begin
        if (in_valid) begin
          acc_d = mac_next;
          sat_d = sat_q | mac_clamped;
          if (cnt_q == LastCnt) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE: begin
        // Result is held until taken; the block reopens only on the following cycle.
        if (out_ready) begin
          acc_d   = '0;
          cnt_d   = '0;
          sat_d   = 1'b0;
          state_d = ACCUM;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sat_q   <= sat_d;
    end
  end

  always_comb begin
    in_ready  = (state_q == ACCUM);
    out_valid = (state_q == DONE);
    // Mid-vector saturation is only reported alongside a finished result.
    out_sat   = out_valid & sat_q;
    out_sum   = '0;
    if (out_valid) begin
`ifdef DOT_ACCUM_RELU_EN
      out_sum = acc_q[ACC_W-1] ? '0 : acc_q;
`else
      out_sum = acc_q;
`endif
    end
  end

endmodule

// File: tb/tb_dot_accum.sv
module tb_dot_accum;

  localparam int unsigned DATA_W  = 5;
  localparam int unsigned ACC_W   = 10;
  localparam int unsigned N_TERMS = 4;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_a;
  logic signed [DATA_W-1:0] in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_sum;
  logic                     out_sat;

  int total = 0;
  int bad   = 0;

  // Scoreboard of expected results, filled by the stimulus, drained by the monitor.
  int exp_sum_q[$];
  int exp_sat_q[$];

  // Bench-side reference accumulator.
  int m_acc;
  int m_cnt;
  int m_sat;

  // Output stability tracking while backpressured.
  logic                    hold_vld = 1'b0;
  logic signed [ACC_W-1:0] hold_sum;
  logic                    hold_sat;

  dot_accum #(
    .DATA_W  (DATA_W),
    .ACC_W   (ACC_W),
    .N_TERMS (N_TERMS)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int clamp(input int v);
    int hi;
    int lo;
    hi = (1 << (ACC_W - 1)) - 1;
    lo = -(1 << (ACC_W - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int present(input int v);
`ifdef DOT_ACCUM_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  task automatic model_clear();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 0;
  endtask

  // Offer one pair (in_valid=1) for one cycle; the pair must be accepted.
  task automatic put(input int a, input int b);
    int raw;
    in_valid = 1'b1;
    in_a     = DATA_W'(a);
    in_b     = DATA_W'(b);
    check("in_ready_before_accept", 32'(in_ready), 1);
    if (m_cnt == N_TERMS - 1) check("no_early_out_valid", 32'(out_valid), 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    raw = m_acc + a * b;
    if (clamp(raw) != raw) m_sat = 1;
    m_acc = clamp(raw);
    m_cnt++;
    if (m_cnt == N_TERMS) begin
      exp_sum_q.push_back(present(m_acc));
      exp_sat_q.push_back(m_sat);
      check("out_valid_latency", 32'(out_valid), 1);
      check("in_ready_in_done", 32'(in_ready), 0);
      model_clear();
    end
  endtask

  // One cycle with in_valid low and junk operands: nothing may be accepted.
  task automatic idle(input int a, input int b);
    in_valid = 1'b0;
    in_a     = DATA_W'(a);
    in_b     = DATA_W'(b);
    @(posedge clk);
    #1;
  endtask

  // Bounded wait for the block to reopen after a result.
  task automatic wait_ready();
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (in_ready !== 1'b1) check("wait_ready_timeout", 32'(in_ready), 1);
  endtask

  // Monitor: pops the scoreboard on each result handshake; checks zero/stable outputs.
  always @(negedge clk) begin
    if (!rst) begin
      if (!out_valid) begin
        check("out_sum_zero_when_idle", 32'(out_sum), 0);
        hold_vld <= 1'b0;
      end else begin
        if (hold_vld) begin
          check("out_sum_stable", 32'(out_sum), 32'(hold_sum));
          check("out_sat_stable", 32'(out_sat), 32'(hold_sat));
        end
        if (out_ready) begin
          if (exp_sum_q.size() == 0) begin
            check("unexpected_result", 32'(out_sum), 32'hdead);
          end else begin
            check("out_sum", 32'(out_sum), exp_sum_q.pop_front());
            check("out_sat", 32'(out_sat), exp_sat_q.pop_front());
          end
          hold_vld <= 1'b0;
        end else begin
          hold_vld <= 1'b1;
          hold_sum <= out_sum;
          hold_sat <= out_sat;
        end
      end
    end
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_a      = 5'sd3;
    in_b      = 5'sd3;
    out_ready = 1'b1;
    model_clear();
    #1;
    // Reset state, with in_valid asserted to show nothing is taken while held.
    check("rst_in_ready", 32'(in_ready), 1);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sum", 32'(out_sum), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    rst      = 1'b0;
    check("post_rst_in_ready", 32'(in_ready), 1);

    // Mixed-sign products, expected -83 (or 0 with ReLU).
    put(2, -12);
    put(1, 0);
    put(15, -4);
    put(1, 1);
    wait_ready();

    // Saturation at the positive rail, then a clean vector clears the sticky flag.
    repeat (4) put(-16, -16);
    wait_ready();
    repeat (4) put(1, 1);
    wait_ready();

    // Negative rail.
    repeat (4) put(-16, 15);
    wait_ready();

    // Backpressure: result held three cycles, taken on the fourth.
    out_ready = 1'b0;
    put(7, 3);
    put(-5, 2);
    put(4, 4);
    put(-1, 9);
    repeat (3) begin
      @(posedge clk);
      #1;
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_in_ready", 32'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_in_ready_after_hs", 32'(in_ready), 1);
    check("bp_out_valid_after_hs", 32'(out_valid), 0);

    // Reset mid-vector discards the partial sum.
    put(3, 3);
    put(3, 3);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 32'(in_ready), 1);
    check("midrst_out_sum", 32'(out_sum), 0);
    #2;
    rst = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    repeat (4) put(1, 2);
    wait_ready();

    // Reset while a result waits in DONE also discards it.
    out_ready = 1'b0;
    repeat (4) put(5, 5);
    void'(exp_sum_q.pop_back());
    void'(exp_sat_q.pop_back());
    #2;
    rst = 1'b1;
    #2;
    check("done_rst_out_valid", 32'(out_valid), 0);
    rst       = 1'b0;
    out_ready = 1'b1;
    model_clear();
    @(posedge clk);
    #1;

    // Gappy in_valid pattern 1,0,0,1,0,1,1 with junk on idle cycles.
    put(1, 1);
    idle(7, 7);
    idle(-8, 6);
    put(1, 1);
    idle(15, 15);
    put(1, 1);
    put(1, 1);
    wait_ready();

    // Drain with a cycle bound.
    for (int i = 0; i < 20 && exp_sum_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check("scoreboard_empty", exp_sum_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
